// File: rtl/cu_sequencer.sv
// Control-unit sequencer: fetch / decode / execute FSM producing the 32-bit
// datapath control word for a small accumulator machine.
module cu_sequencer #(
  parameter int unsigned OP_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [OP_W-1:0] opcode,
  input  logic            acc_neg,
  output logic [31:0]     control_signal,
  output logic            busy,
  output logic            halted
);

  typedef enum logic [3:0] {
    S_IDLE, S_F1, S_F2, S_F3, S_DEC, S_E1, S_E2, S_E3, S_E4, S_HALT
  } state_t;

  localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_STORE = OP_W'(2);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_JMP   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_JGEZ  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_CLR   = OP_W'(7);
  localparam logic [OP_W-1:0] OP_HALT  = OP_W'(8);

  state_t          r_state;
  logic [OP_W-1:0] r_op_q;
  logic            r_take_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_op_q   <= '0;
      r_take_q <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: if (start) r_state <= S_F1;
        S_F1:   r_state <= S_F2;
        S_F2:   r_state <= S_F3;
        S_F3:   r_state <= S_DEC;
        S_DEC: begin
          r_op_q   <= opcode;
          r_take_q <= ~acc_neg;
          if (opcode == OP_HALT)
            r_state <= S_HALT;
          else if (opcode >= OP_LOAD && opcode <= OP_CLR)
            r_state <= S_E1;
          else
            r_state <= S_F1;
        end
        // Execute length depends on the latched opcode only.
        S_E1:
          if (r_op_q == OP_LOAD || r_op_q == OP_STORE ||
              r_op_q == OP_ADD  || r_op_q == OP_SUB)
            r_state <= S_E2;
          else
            r_state <= S_F1;
        S_E2:
          if (r_op_q == OP_LOAD || r_op_q == OP_ADD || r_op_q == OP_SUB)
            r_state <= S_E3;
          else
            r_state <= S_F1;
        S_E3:
          if (r_op_q == OP_ADD || r_op_q == OP_SUB)
            r_state <= S_E4;
          else
            r_state <= S_F1;
        S_E4:   r_state <= S_F1;
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    control_signal = '0;
    busy           = (r_state != S_IDLE) && (r_state != S_HALT);
    halted         = (r_state == S_HALT);
    unique case (r_state)
      S_F1: control_signal[0] = 1'b1;
      S_F2: control_signal[1] = 1'b1;
      S_F3: begin
        control_signal[2] = 1'b1;
        control_signal[3] = 1'b1;
      end
      S_E1: begin
        if (r_op_q == OP_LOAD || r_op_q == OP_STORE ||
            r_op_q == OP_ADD  || r_op_q == OP_SUB)
          control_signal[4] = 1'b1;
        if (r_op_q == OP_STORE) control_signal[6]  = 1'b1;
        if (r_op_q == OP_JMP)   control_signal[8]  = 1'b1;
        if (r_op_q == OP_JGEZ)  control_signal[8]  = r_take_q;
        if (r_op_q == OP_CLR)   control_signal[21] = 1'b1;
      end
      S_E2: begin
        if (r_op_q == OP_LOAD || r_op_q == OP_ADD || r_op_q == OP_SUB)
          control_signal[1] = 1'b1;
        if (r_op_q == OP_STORE) control_signal[7] = 1'b1;
      end
      S_E3: begin
        if (r_op_q == OP_LOAD) control_signal[11] = 1'b1;
        if (r_op_q == OP_ADD || r_op_q == OP_SUB) control_signal[5] = 1'b1;
      end
      S_E4: begin
        if (r_op_q == OP_ADD) control_signal[9]  = 1'b1;
        if (r_op_q == OP_SUB) control_signal[10] = 1'b1;
        if (r_op_q == OP_ADD || r_op_q == OP_SUB) control_signal[12] = 1'b1;
      end
      default: control_signal = '0;
    endcase
  end

endmodule

// File: tb/tb_cu_sequencer.sv
// Bench for cu_sequencer: directed scenarios with literal expectations, then
// random stimulus checked every cycle against a queue-of-words reference model.
module tb_cu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  opcode;
  logic        acc_neg;
  logic [31:0] control_signal;
  logic        busy;
  logic        halted;

  int n_chk  = 0;
  int n_pass = 0;

  cu_sequencer #(.OP_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .opcode         (opcode),
    .acc_neg        (acc_neg),
    .control_signal (control_signal),
    .busy           (busy),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  // Model: remaining control words of the running instruction, one per cycle.
  typedef struct {
    logic [31:0] w;
    bit          dec;
  } item_t;

  item_t mq[$];
  int    m_mode = 0;  // 0 idle, 1 running, 2 halted

  task automatic push(input logic [31:0] w, input bit dec);
    item_t it;
    it.w = w;
    it.dec = dec;
    mq.push_back(it);
  endtask

  task automatic push_fetch();
    push(32'h1, 0);
    push(32'h2, 0);
    push(32'hC, 0);
    push(32'h0, 1);
  endtask

  task automatic push_exec(input logic [7:0] op, input logic neg);
    case (op)
      8'h01: begin push(32'h10, 0); push(32'h2, 0); push(32'h800, 0); end
      8'h02: begin push(32'h50, 0); push(32'h80, 0); end
      8'h03: begin push(32'h10, 0); push(32'h2, 0); push(32'h20, 0); push(32'h1200, 0); end
      8'h04: begin push(32'h10, 0); push(32'h2, 0); push(32'h20, 0); push(32'h1400, 0); end
      8'h05: push(32'h100, 0);
      8'h06: push(neg ? 32'h0 : 32'h100, 0);
      8'h07: push(32'h0020_0000, 0);
      default: ;
    endcase
  endtask

  task automatic model_update();
    item_t it;
    if (!rst) begin
      m_mode = 0;
      mq.delete();
    end else if (m_mode == 0) begin
      if (start) begin
        m_mode = 1;
        push_fetch();
      end
    end else if (m_mode == 1) begin
      it = mq.pop_front();
      if (it.dec) begin
        if (opcode == 8'h08) begin
          m_mode = 2;
          mq.delete();
        end else begin
          push_exec(opcode, acc_neg);
        end
      end
      if (m_mode == 1 && mq.size() == 0) push_fetch();
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic compare();
    logic [31:0] e_cs;
    e_cs = (m_mode == 1) ? mq[0].w : 32'h0;
    check32("model_cs", control_signal, e_cs);
    check1("model_busy", busy, m_mode == 1);
    check1("model_halted", halted, m_mode == 2);
  endtask

  // One clock: model advances with the inputs the DUT saw, then outputs compared.
  task automatic step(input bit chk_lit, input logic [31:0] lit);
    @(posedge clk);
    model_update();
    #1;
    compare();
    if (chk_lit) check32("literal_cs", control_signal, lit);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step(0, 32'h0);
  endtask

  initial begin
    logic [7:0] ops [0:10];
    ops = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'hFF};

    rst = 1'b0; start = 1'b1; opcode = 8'h03; acc_neg = 1'b0;
    step(1, 32'h0);
    check1("reset_busy", busy, 1'b0);
    check1("reset_halted", halted, 1'b0);
    start = 1'b0;
    step(1, 32'h0);
    rst = 1'b1;
    step(1, 32'h0);

    // ADD walk-through
    start = 1'b1;
    step(1, 32'h1);
    start = 1'b0;
    step(1, 32'h2); step(1, 32'hC); step(1, 32'h0);
    step(1, 32'h10); step(1, 32'h2); step(1, 32'h20);
    step(1, 32'h1200);
    check1("add_busy_e4", busy, 1'b1);
    step(1, 32'h1);

    // JGEZ taken, acc_neg flipped during E1
    opcode = 8'h06; acc_neg = 1'b0;
    step(1, 32'h2); step(1, 32'hC); step(1, 32'h0);
    step(1, 32'h100);
    acc_neg = 1'b1;
    step(1, 32'h1);
    // JGEZ not taken
    step(1, 32'h2); step(1, 32'hC); step(1, 32'h0);
    step(1, 32'h0);
    acc_neg = 1'b0;
    step(1, 32'h1);

    // CLR
    opcode = 8'h07;
    step(1, 32'h2); step(1, 32'hC); step(1, 32'h0);
    step(1, 32'h0020_0000);
    step(1, 32'h1);

    // NOP
    opcode = 8'hFF;
    step(1, 32'h2); step(1, 32'hC); step(1, 32'h0);
    step(1, 32'h1);

    // LOAD aborted by reset in E2
    opcode = 8'h01;
    step(1, 32'h2); step(1, 32'hC); step(1, 32'h0);
    step(1, 32'h10); step(1, 32'h2);
    rst = 1'b0; start = 1'b1;
    step(1, 32'h0);
    check1("abort_busy", busy, 1'b0);
    rst = 1'b1; start = 1'b0;
    step(1, 32'h0);
    start = 1'b1;
    step(1, 32'h1);
    start = 1'b0;

    // HALT
    opcode = 8'h08;
    step(1, 32'h2); step(1, 32'hC); step(1, 32'h0);
    step(1, 32'h0);
    check1("halt_halted", halted, 1'b1);
    check1("halt_busy", busy, 1'b0);
    start = 1'b1;
    step(1, 32'h0); step(1, 32'h0);
    check1("halt_sticky", halted, 1'b1);
    start = 1'b0;
    rst = 1'b0;
    step(1, 32'h0);
    check1("halt_reset", halted, 1'b0);
    rst = 1'b1;
    step(1, 32'h0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 39) != 0);
      start   = ($urandom_range(0, 3) == 0);
      opcode  = ($urandom_range(0, 4) == 0) ? 8'($urandom) : ops[$urandom_range(0, 10)];
      acc_neg = 1'($urandom);
      step(0, 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cu_sequencer.md
CU_SEQUENCER -- requirements
Module: cu_sequencer

Interface
REQ-001 SHALL have parameter: OP_W, 8, opcode width of the IR opcode field.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port: start  input  1  request to leave IDLE and begin fetching.
REQ-005 SHALL have port: opcode  input  OP_W  IR opcode field; sampled only in DEC.
REQ-006 SHALL have port: acc_neg  input  1  ACC sign bit (ACC[15]); sampled only in DEC.
REQ-007 SHALL have port: control_signal  output  32  datapath control word.
REQ-008 SHALL have port: busy  output  1  high in every state except IDLE and HALT.
REQ-009 SHALL have port: halted  output  1  high only in HALT.

Function
REQ-010 SHALL use this control bit map: [0] PC->MAR, [1] mem read->MBR, [2] MBR->IR, [3] PC+1, [4] IR addr->MAR, [5] MBR->BR, [6] ACC->MBR, [7] mem write, [8] IR addr->PC, [9] ALU add, [10] ALU sub, [12] ALU->ACC, [11] MBR->ACC, [21] ACC clear; all other bits always 0.
REQ-011 SHALL implement states IDLE, F1, F2, F3, DEC, E1, E2, E3, E4, HALT, with exactly one transition per clk edge.
REQ-012 SHALL drive control_signal, busy and halted as a pure decode of the state register, latched opcode (op_q) and latched branch flag (take_q); no input feeds outputs combinationally.
REQ-013 IDLE: output 0; start=1 -> F1, else stay.
REQ-014 F1: bit0 -> F2. F2: bit1 -> F3. F3: bits 2,3 -> DEC.
REQ-015 DEC: output 0; op_q<=opcode, take_q<=~acc_neg; next: 0x08 -> HALT; 0x01-0x07 -> E1; any other opcode is a NOP -> F1.
REQ-016 LOAD 0x01: E1 bit4, E2 bit1, E3 bit11 -> F1.
REQ-017 STORE 0x02: E1 bits 4,6, E2 bit7 -> F1.
REQ-018 ADD 0x03 / SUB 0x04: E1 bit4, E2 bit1, E3 bit5, E4 bit9 (ADD) or bit10 (SUB) plus bit12 -> F1.
REQ-019 JMP 0x05: E1 bit8 -> F1. JGEZ 0x06: E1 bit8 if take_q else 0 -> F1.
REQ-020 CLR 0x07: E1 bit21 -> F1.
REQ-021 HALT: output 0; stays until reset; start ignored.
REQ-022 SHALL ignore start in all states except IDLE.
REQ-023 SHALL take exactly these cycles from F1 back to F1: NOP 4, JMP/JGEZ/CLR 5, STORE 6, LOAD 7, ADD/SUB 8.
REQ-024 SHALL ignore changes on opcode/acc_neg outside DEC; they do not alter the current instruction.

Reset
REQ-025 rst=0 at a rising edge SHALL set state=IDLE, op_q=0, take_q=0; from that edge control_signal=0, busy=0, halted=0.
REQ-026 rst SHALL dominate start and abort any instruction mid-sequence; no partial execute bits appear after the reset edge.

Verification
REQ-027 Reset, start pulse, opcode=0x03 -> control_signal per cycle 0x1, 0x2, 0xC, 0x0, 0x10, 0x2, 0x20, 0x1200, then 0x1; busy=1 throughout.
REQ-028 opcode=0x06 with acc_neg=0 at DEC -> E1 word 0x100; repeat with acc_neg=1 -> E1 word 0x0; acc_neg toggled during E1 has no effect.
REQ-029 opcode=0x07 -> E1 word 0x0020_0000, 5-cycle loop back to F1 (0x1).
REQ-030 opcode=0x08 -> after DEC halted=1, busy=0, control_signal=0; start pulses ignored; rst=0 -> IDLE, halted=0.
REQ-031 LOAD with rst=0 asserted in E2 -> next cycle control_signal=0, busy=0, state IDLE; a later start -> F1 word 0x1.
REQ-032 opcode=0xFF -> DEC -> F1, 4-cycle loop, no bits beyond 0-3 ever asserted.
